// File: rtl/onchip_mem_dma_pkg.sv
// Shared types and defaults for the on-chip memory DMA initiator.
package onchip_mem_dma_pkg;

  localparam int DEF_ADDR_W = 11;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_BE_W   = DEF_DATA_W / 8;
  localparam int DEF_LEN_W  = 12;

  localparam logic [1:0] OP_FILL  = 2'd0;
  localparam logic [1:0] OP_COPY  = 2'd1;
  localparam logic [1:0] OP_CHECK = 2'd2;

  typedef enum logic [2:0] {
    S_IDLE, S_FILL, S_CP_RD, S_CP_CAP, S_CP_WR, S_CK_RD, S_CK_LAST, S_DONE
  } state_t;

endpackage

// File: rtl/onchip_mem_dma_if.sv
// Avalon-MM port between the DMA initiator (master) and the on-chip memory (slave).
interface onchip_mem_dma_if #(
  parameter int ADDR_W = onchip_mem_dma_pkg::DEF_ADDR_W,
  parameter int DATA_W = onchip_mem_dma_pkg::DEF_DATA_W,
  parameter int BE_W   = onchip_mem_dma_pkg::DEF_BE_W
);
  import onchip_mem_dma_pkg::*;

  logic [ADDR_W-1:0] m_address;
  logic [BE_W-1:0]   m_byteenable;
  logic              m_chipselect;
  logic              m_write;
  logic [DATA_W-1:0] m_writedata;
  logic              m_clken;
  logic              m_debugaccess;
  logic [DATA_W-1:0] m_readdata;

  modport master (
    output m_address, m_byteenable, m_chipselect, m_write, m_writedata,
           m_clken, m_debugaccess,
    input  m_readdata
  );

  modport slave (
    input  m_address, m_byteenable, m_chipselect, m_write, m_writedata,
           m_clken, m_debugaccess,
    output m_readdata
  );

endinterface

// File: rtl/onchip_mem_dma_pattern.sv
// Word pattern generator: pattern_i = base + (incr ? i : 0), modulo 2^DATA_W.
module onchip_mem_dma_pattern import onchip_mem_dma_pkg::*; #(
  parameter int DATA_W = DEF_DATA_W,
  parameter int LEN_W  = DEF_LEN_W
) (
  input  logic [DATA_W-1:0] base,
  input  logic              incr,
  input  logic [LEN_W-1:0]  index,
  output logic [DATA_W-1:0] pattern
);

  assign pattern = base + (incr ? DATA_W'(index) : '0);

endmodule

// File: rtl/onchip_mem_dma.sv
// Single-channel FILL/COPY/CHECK engine driving the 2048x32 on-chip memory port.
module onchip_mem_dma import onchip_mem_dma_pkg::*; #(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int BE_W   = DEF_BE_W,
  parameter int LEN_W  = DEF_LEN_W
) (
  input  logic              clk,
  input  logic              reset,
  // Command handshake: a command is taken on a rising edge where
  // cmd_valid && cmd_ready; cmd_ready is high only in IDLE, so cmd_valid
  // seen while busy is neither latched nor queued.
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [ADDR_W-1:0] cmd_src,
  input  logic [ADDR_W-1:0] cmd_dst,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic [DATA_W-1:0] cmd_pattern,
  input  logic              cmd_incr,
  output logic              busy,
  output logic              done,
  output logic [LEN_W-1:0]  err_count,
  output logic [ADDR_W-1:0] err_addr,
  output state_t            dbg_state,
  onchip_mem_dma_if.master  mem
);

  state_t            state, state_n;
  logic [LEN_W-1:0]  idx, len_q, idx_prev, pat_idx;
  logic [ADDR_W-1:0] src_q, dst_q, chk_addr;
  logic [DATA_W-1:0] pat_q, word_q, pattern;
  logic              incr_q, last, chk_en, mismatch;

  assign idx_prev = idx - LEN_W'(1);
  assign last     = (idx == len_q - LEN_W'(1));
  // CHECK compares the word read one cycle earlier, so it uses index i-1.
  assign pat_idx  = (state == S_CK_RD || state == S_CK_LAST) ? idx_prev : idx;
  assign chk_en   = (state == S_CK_RD && idx != '0) || state == S_CK_LAST;
  assign chk_addr = dst_q + idx_prev[ADDR_W-1:0];
  assign mismatch = chk_en && (mem.m_readdata != pattern);

  onchip_mem_dma_pattern #(.DATA_W(DATA_W), .LEN_W(LEN_W)) u_pattern (
    .base    (pat_q),
    .incr    (incr_q),
    .index   (pat_idx),
    .pattern (pattern)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      idx       <= '0;
      len_q     <= '0;
      src_q     <= '0;
      dst_q     <= '0;
      pat_q     <= '0;
      incr_q    <= 1'b0;
      word_q    <= '0;
      err_count <= '0;
      err_addr  <= '0;
    end else begin
      state <= state_n;
      case (state)
        S_IDLE: if (cmd_valid) begin
          idx       <= '0;
          len_q     <= cmd_len;
          src_q     <= cmd_src;
          dst_q     <= cmd_dst;
          pat_q     <= cmd_pattern;
          incr_q    <= cmd_incr;
          err_count <= '0;
          err_addr  <= '0;
        end
        S_FILL, S_CP_WR, S_CK_RD: idx <= idx + LEN_W'(1);
        S_CP_CAP: word_q <= mem.m_readdata;
        default: ;
      endcase
      // err_count only returns to zero on a new command, so zero marks the first miss.
      if (mismatch) begin
        if (err_count != '1) err_count <= err_count + LEN_W'(1);
        if (err_count == '0) err_addr <= chk_addr;
      end
    end
  end

  always_comb begin
    state_n = state;
    case (state)
      S_IDLE: if (cmd_valid) begin
        if (cmd_len == '0) state_n = S_DONE;
        else begin
          case (cmd_op)
            OP_FILL:  state_n = S_FILL;
            OP_COPY:  state_n = S_CP_RD;
            OP_CHECK: state_n = S_CK_RD;
            default:  state_n = S_DONE;
          endcase
        end
      end
      S_FILL:    if (last) state_n = S_DONE;
      S_CP_RD:   state_n = S_CP_CAP;
      S_CP_CAP:  state_n = S_CP_WR;
      S_CP_WR:   state_n = last ? S_DONE : S_CP_RD;
      S_CK_RD:   if (last) state_n = S_CK_LAST;
      S_CK_LAST: state_n = S_DONE;
      S_DONE:    state_n = S_IDLE;
      default:   state_n = S_IDLE;
    endcase
  end

  always_comb begin
    mem.m_address    = '0;
    mem.m_chipselect = 1'b0;
    mem.m_write      = 1'b0;
    mem.m_writedata  = '0;
    case (state)
      S_FILL: begin
        mem.m_address    = dst_q + idx[ADDR_W-1:0];
        mem.m_chipselect = 1'b1;
        mem.m_write      = 1'b1;
        mem.m_writedata  = pattern;
      end
      S_CP_RD: begin
        mem.m_address    = src_q + idx[ADDR_W-1:0];
        mem.m_chipselect = 1'b1;
      end
      S_CP_WR: begin
        mem.m_address    = dst_q + idx[ADDR_W-1:0];
        mem.m_chipselect = 1'b1;
        mem.m_write      = 1'b1;
        mem.m_writedata  = word_q;
      end
      S_CK_RD: begin
        mem.m_address    = dst_q + idx[ADDR_W-1:0];
        mem.m_chipselect = 1'b1;
      end
      default: ;
    endcase
  end

  assign mem.m_byteenable  = {BE_W{mem.m_chipselect}};
  assign mem.m_debugaccess = mem.m_write;
  assign mem.m_clken       = ~reset;
  assign cmd_ready         = (state == S_IDLE);
  assign busy              = (state != S_IDLE);
  assign done              = (state == S_DONE);
  assign dbg_state         = state;

endmodule

// File: tb/tb_onchip_mem_dma.sv
// Self-checking bench for onchip_mem_dma with a one-cycle-latency memory model.
module tb_onchip_mem_dma;
  import onchip_mem_dma_pkg::*;

  localparam int AW = 11;
  localparam int DW = 32;
  localparam int LW = 12;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [1:0]    cmd_op = '0;
  logic [AW-1:0] cmd_src = '0;
  logic [AW-1:0] cmd_dst = '0;
  logic [LW-1:0] cmd_len = '0;
  logic [DW-1:0] cmd_pattern = '0;
  logic          cmd_incr = 1'b0;
  logic          busy, done;
  logic [LW-1:0] err_count;
  logic [AW-1:0] err_addr;
  state_t        dbg_state;

  logic [DW-1:0] ram [0:2047];
  logic [DW-1:0] rdata;
  logic          bd_en = 1'b0;
  logic [AW-1:0] bd_addr = '0;
  logic [DW-1:0] bd_data = '0;

  logic [AW+DW-1:0] exp_q[$];
  int checks = 0;
  int failures = 0;

  onchip_mem_dma_if bus ();

  onchip_mem_dma dut (
    .clk         (clk),
    .reset       (reset),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_op      (cmd_op),
    .cmd_src     (cmd_src),
    .cmd_dst     (cmd_dst),
    .cmd_len     (cmd_len),
    .cmd_pattern (cmd_pattern),
    .cmd_incr    (cmd_incr),
    .busy        (busy),
    .done        (done),
    .err_count   (err_count),
    .err_addr    (err_addr),
    .dbg_state   (dbg_state),
    .mem         (bus)
  );

  // ---------------- clock / memory model ----------------
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bd_en) ram[bd_addr] <= bd_data;
    else if (bus.m_clken && bus.m_chipselect) begin
      if (bus.m_write) ram[bus.m_address] <= bus.m_writedata;
      rdata <= ram[bus.m_address];
    end
  end
  assign bus.m_readdata = rdata;

  // ---------------- driver tasks ----------------
  task automatic bd_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
    @(negedge clk);
    bd_en = 1'b1; bd_addr = a; bd_data = d;
    @(negedge clk);
    bd_en = 1'b0;
  endtask

  task automatic push_writes(input logic [AW-1:0] dst, input int len,
                             input logic [DW-1:0] pat, input logic incr);
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    for (int i = 0; i < len; i++) begin
      a = dst + AW'(i);
      d = pat + (incr ? DW'(i) : '0);
      exp_q.push_back({a, d});
    end
  endtask

  // Scoreboard: every effective write is popped against the expected queue.
  task automatic sb_sample();
    logic [AW+DW-1:0] got, exp;
    if (bus.m_chipselect === 1'b1 && bus.m_write === 1'b1 && bus.m_clken === 1'b1) begin
      got = {bus.m_address, bus.m_writedata};
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL sb_write unexpected got=%h", got);
      end else begin
        exp = exp_q.pop_front();
        if (got !== exp) begin
          failures++;
          $display("FAIL sb_write got=%h expected=%h", got, exp);
        end
      end
    end
    if (bus.m_chipselect === 1'b1) begin
      checks++;
      if (bus.m_byteenable !== 4'hF) begin
        failures++;
        $display("FAIL byteenable got=%h expected=f", bus.m_byteenable);
      end
    end else if (bus.m_write !== 1'b0 || bus.m_writedata !== '0) begin
      checks++;
      failures++;
      $display("FAIL idle_bus write=%b writedata=%h expected 0/0", bus.m_write, bus.m_writedata);
    end
  endtask

  task automatic run_cmd(input logic [1:0] op, input logic [AW-1:0] src, input logic [AW-1:0] dst,
                         input logic [LW-1:0] len, input logic [DW-1:0] pat, input logic incr,
                         input bit hold, output int done_cyc, output int cs_cnt, output int bad);
    @(negedge clk);
    cmd_op = op; cmd_src = src; cmd_dst = dst; cmd_len = len;
    cmd_pattern = pat; cmd_incr = incr; cmd_valid = 1'b1;
    @(posedge clk);
    #1;
    if (hold) begin
      cmd_dst = dst ^ AW'(11'h040);
      cmd_pattern = ~pat;
    end else cmd_valid = 1'b0;
    done_cyc = -1; cs_cnt = 0; bad = 0;
    for (int k = 1; k <= 200; k++) begin
      @(negedge clk);
      sb_sample();
      if (bus.m_chipselect === 1'b1) cs_cnt++;
      if (busy !== 1'b1 || cmd_ready !== 1'b0 || bus.m_debugaccess !== bus.m_write) bad++;
      if (done === 1'b1) begin
        done_cyc = k;
        break;
      end
    end
    cmd_valid = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (cmd_ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
      failures++;
      $display("FAIL reset_ctrl ready/busy/done=%b%b%b expected 100", cmd_ready, busy, done);
    end
    checks++;
    if (err_count !== '0 || err_addr !== '0) begin
      failures++;
      $display("FAIL reset_err count=%0d addr=%h expected 0/0", err_count, err_addr);
    end
    checks++;
    if (bus.m_address !== '0 || bus.m_chipselect !== 1'b0 || bus.m_write !== 1'b0 ||
        bus.m_writedata !== '0 || bus.m_byteenable !== '0 || bus.m_debugaccess !== 1'b0) begin
      failures++;
      $display("FAIL reset_bus addr=%h cs=%b wr=%b wd=%h be=%h dbg=%b expected all 0",
               bus.m_address, bus.m_chipselect, bus.m_write, bus.m_writedata,
               bus.m_byteenable, bus.m_debugaccess);
    end
    checks++;
    if (bus.m_clken !== 1'b0) begin
      failures++;
      $display("FAIL reset_clken got=%b expected=0", bus.m_clken);
    end
    checks++;
    if (dbg_state !== S_IDLE) begin
      failures++;
      $display("FAIL reset_state got=%0d expected=%0d", dbg_state, S_IDLE);
    end
    reset = 1'b0;
    #1;
    checks++;
    if (bus.m_clken !== 1'b1) begin
      failures++;
      $display("FAIL run_clken got=%b expected=1", bus.m_clken);
    end
  endtask

  task automatic test_fill();
    int dc, cs, bb;
    logic [DW-1:0] e;
    push_writes(11'h010, 4, 32'hA5A50000, 1'b1);
    run_cmd(OP_FILL, '0, 11'h010, 12'd4, 32'hA5A50000, 1'b1, 1'b0, dc, cs, bb);
    checks++;
    if (dc !== 5) begin failures++; $display("FAIL fill_done_cycle got=%0d expected=5", dc); end
    checks++;
    if (cs !== 4) begin failures++; $display("FAIL fill_accesses got=%0d expected=4", cs); end
    checks++;
    if (bb !== 0) begin failures++; $display("FAIL fill_busy_ready_dbg bad_cycles=%0d expected=0", bb); end
    checks++;
    if (exp_q.size() !== 0) begin failures++; $display("FAIL fill_sb_left got=%0d expected=0", exp_q.size()); end
    for (int i = 0; i < 4; i++) begin
      e = 32'hA5A50000 + DW'(i);
      checks++;
      if (ram[11'h010 + i] !== e) begin
        failures++;
        $display("FAIL fill_mem[%0d] got=%h expected=%h", i, ram[11'h010 + i], e);
      end
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || cmd_ready !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL fill_after_done done/ready/busy=%b%b%b expected 010", done, cmd_ready, busy);
    end
  endtask

  task automatic test_copy();
    int dc, cs, bb;
    bd_write(11'h7FE, 32'h11112222);
    bd_write(11'h7FF, 32'h33334444);
    bd_write(11'h000, 32'h55556666);
    exp_q.push_back({11'h100, 32'h11112222});
    exp_q.push_back({11'h101, 32'h33334444});
    exp_q.push_back({11'h102, 32'h55556666});
    run_cmd(OP_COPY, 11'h7FE, 11'h100, 12'd3, 32'h0, 1'b0, 1'b0, dc, cs, bb);
    checks++;
    if (dc !== 10) begin failures++; $display("FAIL copy_done_cycle got=%0d expected=10", dc); end
    checks++;
    if (cs !== 6) begin failures++; $display("FAIL copy_accesses got=%0d expected=6", cs); end
    checks++;
    if (bb !== 0) begin failures++; $display("FAIL copy_busy_ready_dbg bad_cycles=%0d expected=0", bb); end
    checks++;
    if (exp_q.size() !== 0) begin failures++; $display("FAIL copy_sb_left got=%0d expected=0", exp_q.size()); end
    checks++;
    if (ram[11'h102] !== 32'h55556666) begin
      failures++;
      $display("FAIL copy_wrap_word got=%h expected=55556666", ram[11'h102]);
    end
  endtask

  task automatic test_check();
    int dc, cs, bb;
    bd_write(11'h012, 32'hDEADBEEF);
    run_cmd(OP_CHECK, '0, 11'h010, 12'd4, 32'hA5A50000, 1'b1, 1'b0, dc, cs, bb);
    checks++;
    if (dc !== 6) begin failures++; $display("FAIL check_done_cycle got=%0d expected=6", dc); end
    checks++;
    if (cs !== 4) begin failures++; $display("FAIL check_reads got=%0d expected=4", cs); end
    checks++;
    if (err_count !== 12'd1 || err_addr !== 11'h012) begin
      failures++;
      $display("FAIL check_dirty count=%0d addr=%h expected 1/012", err_count, err_addr);
    end
    bd_write(11'h012, 32'hA5A50002);
    run_cmd(OP_CHECK, '0, 11'h010, 12'd4, 32'hA5A50000, 1'b1, 1'b0, dc, cs, bb);
    checks++;
    if (dc !== 6 || err_count !== '0 || err_addr !== '0) begin
      failures++;
      $display("FAIL check_clean done=%0d count=%0d addr=%h expected 6/0/000", dc, err_count, err_addr);
    end
    // copy region holds 11112222, 33334444, 55556666: two misses, first at 0x101
    run_cmd(OP_CHECK, '0, 11'h100, 12'd3, 32'h11112222, 1'b0, 1'b0, dc, cs, bb);
    checks++;
    if (dc !== 5 || err_count !== 12'd2 || err_addr !== 11'h101) begin
      failures++;
      $display("FAIL check_multi done=%0d count=%0d addr=%h expected 5/2/101", dc, err_count, err_addr);
    end
    checks++;
    if (bb !== 0 || exp_q.size() !== 0) begin
      failures++;
      $display("FAIL check_ctrl bad_cycles=%0d sb_left=%0d expected 0/0", bb, exp_q.size());
    end
  endtask

  task automatic test_len_zero();
    int dc, cs, bb;
    run_cmd(OP_FILL, '0, 11'h050, 12'd0, 32'h12345678, 1'b0, 1'b0, dc, cs, bb);
    checks++;
    if (dc !== 1 || cs !== 0) begin
      failures++;
      $display("FAIL len0 done=%0d accesses=%0d expected 1/0", dc, cs);
    end
    checks++;
    if (err_count !== '0 || err_addr !== '0) begin
      failures++;
      $display("FAIL len0_err_clear count=%0d addr=%h expected 0/0", err_count, err_addr);
    end
    run_cmd(2'd3, 11'h001, 11'h050, 12'd5, 32'h12345678, 1'b1, 1'b0, dc, cs, bb);
    checks++;
    if (dc !== 1 || cs !== 0 || bb !== 0) begin
      failures++;
      $display("FAIL op3 done=%0d accesses=%0d bad=%0d expected 1/0/0", dc, cs, bb);
    end
  endtask

  task automatic test_busy_ignore();
    int dc, cs, bb, cs_after;
    push_writes(11'h200, 3, 32'h0BAD0000, 1'b1);
    run_cmd(OP_FILL, '0, 11'h200, 12'd3, 32'h0BAD0000, 1'b1, 1'b1, dc, cs, bb);
    cs_after = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      sb_sample();
      if (bus.m_chipselect === 1'b1 || busy !== 1'b0) cs_after++;
    end
    checks++;
    if (dc !== 4 || cs !== 3 || bb !== 0) begin
      failures++;
      $display("FAIL hold_first done=%0d accesses=%0d bad=%0d expected 4/3/0", dc, cs, bb);
    end
    checks++;
    if (cs_after !== 0 || exp_q.size() !== 0) begin
      failures++;
      $display("FAIL hold_no_second extra=%0d sb_left=%0d expected 0/0", cs_after, exp_q.size());
    end
  endtask

  task automatic test_reset_mid();
    int cs_cnt, done_cnt, dc, cs, bb;
    cs_cnt = 0; done_cnt = 0;
    bd_write(11'h300, 32'h0);
    bd_write(11'h301, 32'h0);
    @(negedge clk);
    cmd_op = OP_FILL; cmd_src = '0; cmd_dst = 11'h300; cmd_len = 12'd8;
    cmd_pattern = 32'h12340000; cmd_incr = 1'b1; cmd_valid = 1'b1;
    exp_q.push_back({11'h300, 32'h12340000});
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    @(negedge clk);
    sb_sample();
    @(negedge clk);
    reset = 1'b1;
    #1 sb_sample();
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (k == 2) reset = 1'b0;
      sb_sample();
      if (bus.m_chipselect !== 1'b0) cs_cnt++;
      if (done !== 1'b0) done_cnt++;
    end
    checks++;
    if (cs_cnt !== 0 || done_cnt !== 0) begin
      failures++;
      $display("FAIL abort_quiet cs_cycles=%0d done_cycles=%0d expected 0/0", cs_cnt, done_cnt);
    end
    checks++;
    if (cmd_ready !== 1'b1 || busy !== 1'b0 || exp_q.size() !== 0) begin
      failures++;
      $display("FAIL abort_idle ready=%b busy=%b sb_left=%0d expected 1/0/0", cmd_ready, busy, exp_q.size());
    end
    checks++;
    if (ram[11'h300] !== 32'h12340000 || ram[11'h301] !== 32'h0) begin
      failures++;
      $display("FAIL abort_mem got=%h,%h expected 12340000,00000000", ram[11'h300], ram[11'h301]);
    end
    push_writes(11'h301, 2, 32'h77770000, 1'b1);
    run_cmd(OP_FILL, '0, 11'h301, 12'd2, 32'h77770000, 1'b1, 1'b0, dc, cs, bb);
    checks++;
    if (dc !== 3 || cs !== 2 || bb !== 0 || exp_q.size() !== 0) begin
      failures++;
      $display("FAIL after_abort done=%0d accesses=%0d bad=%0d sb_left=%0d expected 3/2/0/0",
               dc, cs, bb, exp_q.size());
    end
  endtask

  task automatic test_random();
    int dc, cs, bb, len;
    logic [AW-1:0] dst;
    logic [DW-1:0] pat;
    logic incr;
    for (int r = 0; r < 4; r++) begin
      dst = AW'($urandom_range(0, 2047));
      len = $urandom_range(1, 6);
      pat = $urandom;
      incr = 1'($urandom_range(0, 1));
      push_writes(dst, len, pat, incr);
      run_cmd(OP_FILL, '0, dst, LW'(len), pat, incr, 1'b0, dc, cs, bb);
      checks++;
      if (dc !== len + 1 || cs !== len || exp_q.size() !== 0) begin
        failures++;
        $display("FAIL rand_fill[%0d] done=%0d accesses=%0d sb_left=%0d expected %0d/%0d/0",
                 r, dc, cs, exp_q.size(), len + 1, len);
      end
      run_cmd(OP_CHECK, '0, dst, LW'(len), pat, incr, 1'b0, dc, cs, bb);
      checks++;
      if (dc !== len + 2 || err_count !== '0 || err_addr !== '0) begin
        failures++;
        $display("FAIL rand_check[%0d] done=%0d count=%0d addr=%h expected %0d/0/000",
                 r, dc, err_count, err_addr, len + 2);
      end
    end
  endtask

  // ---------------- sequence / report ----------------
  initial begin
    test_reset();
    test_fill();
    test_copy();
    test_check();
    test_len_zero();
    test_busy_ignore();
    test_reset_mid();
    test_random();
    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
